// File: rtl/serial_tx_if.sv
// Nibble handshake and serial output bundle for serial_tx.
// slave = the serializer, master = the nibble producer / observer.
interface serial_tx_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       shift_out;
    logic       frame;
    logic       busy;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output shift_out,
        output frame,
        output busy
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  shift_out,
        input  frame,
        input  busy
    );
endinterface

// File: rtl/serial_tx.sv
// Buffered nibble serializer, MSB first, with optional inter-frame gap.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    serial_tx_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST =
        HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd3
    } state_t;
`endif

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    head;

    state_t        state;
    logic [3:0]    shreg;
    logic [1:0]    bit_cnt;
    logic [3:0]    gap_cnt;
    logic          shift_q;
    logic          frame_q;
`ifdef SERIAL_TX_PARITY_EN
    logic          par_q;
`endif

    assign full  = (count == DEPTH_L);
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = (state == IDLE) && !empty;
    assign head  = mem[rd_ptr];

    assign bus.in_ready  = !full;
    assign bus.shift_out = shift_q;
    assign bus.frame     = frame_q;
    assign bus.busy      = !empty || (state != IDLE) || frame_q;

    // Buffer storage; pointer reset makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Wrap-around pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer with registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shift_q <= 1'b0;
            frame_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    shift_q <= 1'b0;
                    frame_q <= 1'b0;
                    if (!empty) begin
                        shreg   <= head;
                        bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shreg[3];
                    frame_q <= 1'b1;
                    shreg   <= {shreg[2:0], 1'b0};
                    if (bit_cnt == 2'd3) begin
                        bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        state   <= PARITY;
`else
                        gap_cnt <= '0;
                        state   <= HAS_GAP ? GAP : IDLE;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 2'd1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    shift_q <= par_q;
                    frame_q <= 1'b1;
                    gap_cnt <= '0;
                    state   <= HAS_GAP ? GAP : IDLE;
                end
`endif
                GAP: begin
                    shift_q <= 1'b0;
                    frame_q <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    shift_q <= 1'b0;
                    frame_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: dut_a has no gap, dut_b a 3-cycle gap.
// Honours SERIAL_TX_PARITY_EN by expecting a trailing even-parity bit.
module tb_serial_tx;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passes = 0;
    logic q [$];

    serial_tx_if ia ();
    serial_tx_if ib ();

    serial_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    serial_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    always #5 clk = ~clk;

    // Capture every framed bit of dut_a for ordering checks.
    always @(posedge clk) begin
        #1;
        if (ia.frame === 1'b1) begin
            q.push_back(ia.shift_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic frame_chk(input bit sel, input logic [3:0] n,
                             input string tag);
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk($sformatf("%s_frm%0d", tag, i),
                sel ? ib.frame : ia.frame, 8'd1);
            chk($sformatf("%s_bit%0d", tag, i),
                sel ? ib.shift_out : ia.shift_out, {7'd0, n[i]});
        end
`ifdef SERIAL_TX_PARITY_EN
        tick();
        chk({tag, "_pfrm"}, sel ? ib.frame : ia.frame, 8'd1);
        chk({tag, "_par"}, sel ? ib.shift_out : ia.shift_out,
            {7'd0, ^n});
`endif
    endtask

    initial begin
        logic [3:0] nib [5];
        logic [3:0] got;
        logic [0:5] rdy_exp;
        int n;

        rst         = 1'b1;
        ia.in_valid = 1'b0;
        ia.in_data  = 4'h0;
        ib.in_valid = 1'b0;
        ib.in_data  = 4'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of both instances
        chk("rst_a_shift", ia.shift_out, 8'd0);
        chk("rst_a_frame", ia.frame, 8'd0);
        chk("rst_a_busy", ia.busy, 8'd0);
        chk("rst_a_ready", ia.in_ready, 8'd1);
        chk("rst_b_frame", ib.frame, 8'd0);
        chk("rst_b_ready", ib.in_ready, 8'd1);

        // Push presented with rst high is discarded
        rst         = 1'b1;
        ia.in_valid = 1'b1;
        ia.in_data  = 4'hF;
        tick();
        rst         = 1'b0;
        ia.in_valid = 1'b0;
        chk("rstpush_busy", ia.busy, 8'd0);
        chk("rstpush_ready", ia.in_ready, 8'd1);
        tick();
        tick();
        chk("rstpush_frame", ia.frame, 8'd0);
        chk("rstpush_busy2", ia.busy, 8'd0);

        // Single nibble 1010: pop one edge after push, bits next
        ia.in_valid = 1'b1;
        ia.in_data  = 4'b1010;
        tick();
        ia.in_valid = 1'b0;
        chk("s1_busy_push", ia.busy, 8'd1);
        tick();
        chk("s1_frame_pop", ia.frame, 8'd0);
        frame_chk(1'b0, 4'b1010, "s1");
        tick();
        chk("s1_end_frame", ia.frame, 8'd0);
        chk("s1_end_shift", ia.shift_out, 8'd0);
        chk("s1_end_busy", ia.busy, 8'd0);

        // Back-to-back 1101, 0110 with a single idle slot
        ia.in_valid = 1'b1;
        ia.in_data  = 4'b1101;
        tick();
        ia.in_data  = 4'b0110;
        tick();
        ia.in_valid = 1'b0;
        chk("b2b_frame_pop", ia.frame, 8'd0);
        frame_chk(1'b0, 4'b1101, "b2b_a");
        tick();
        chk("b2b_gap_frame", ia.frame, 8'd0);
        chk("b2b_gap_shift", ia.shift_out, 8'd0);
        frame_chk(1'b0, 4'b0110, "b2b_b");
        tick();
        chk("b2b_end_busy", ia.busy, 8'd0);

        // Parity-relevant nibble 1011
        ia.in_valid = 1'b1;
        ia.in_data  = 4'b1011;
        tick();
        ia.in_valid = 1'b0;
        tick();
        frame_chk(1'b0, 4'b1011, "par");
        tick();
        chk("par_end_frame", ia.frame, 8'd0);

        // Overflow: six pushes, the sixth finds the buffer full
        nib     = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        rdy_exp = 6'b111110;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 4'(i + 1);
            chk($sformatf("ovf_ready%0d", i), ia.in_ready,
                {7'd0, rdy_exp[i]});
            tick();
        end
        ia.in_valid = 1'b0;
        chk("ovf_full_hold", ia.in_ready, 8'd0);
        n = 0;
        while (ia.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ovf_ready_back", ia.in_ready, 8'd1);
        n = 0;
        while (ia.busy !== 1'b0 && n < 80) begin
            tick();
            n++;
        end
        chk("ovf_drained", ia.busy, 8'd0);
        chk("ovf_bits", 8'(q.size()), 8'(5 * FL));
        for (int k = 0; k < 5; k++) begin
            got = '0;
            for (int b = 0; b < FL; b++) begin
                if (q.size() > 0) begin
                    if (b < 4) got = {got[2:0], q.pop_front()};
                    else void'(q.pop_front());
                end
            end
            chk($sformatf("ovf_nib%0d", k), {4'd0, got}, {4'd0, nib[k]});
        end

        // Gap instance: 3 gap cycles plus one idle cycle between frames
        ib.in_valid = 1'b1;
        ib.in_data  = 4'b1001;
        tick();
        ib.in_data  = 4'b0111;
        tick();
        ib.in_valid = 1'b0;
        frame_chk(1'b1, 4'b1001, "gap_a");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("gap_frame%0d", i), ib.frame, 8'd0);
            chk($sformatf("gap_shift%0d", i), ib.shift_out, 8'd0);
        end
        frame_chk(1'b1, 4'b0111, "gap_b");
        tick();
        chk("gap2_busy", ib.busy, 8'd1);
        tick();
        tick();
        chk("gap2_done", ib.busy, 8'd0);

        // Reset during bit 2 with two nibbles queued
        ia.in_valid = 1'b1;
        ia.in_data  = 4'b1001;
        tick();
        ia.in_data  = 4'b0011;
        tick();
        ia.in_data  = 4'b1100;
        tick();
        ia.in_valid = 1'b0;
        chk("abort_b3", ia.shift_out, 8'd1);
        chk("abort_full", ia.in_ready, 8'd1);
        tick();
        chk("abort_b2_frm", ia.frame, 8'd1);
        chk("abort_b2", ia.shift_out, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_frame", ia.frame, 8'd0);
        chk("abort_shift", ia.shift_out, 8'd0);
        chk("abort_ready", ia.in_ready, 8'd1);
        chk("abort_busy", ia.busy, 8'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ia.frame !== 1'b0) n++;
        end
        chk("abort_silent", 8'(n), 8'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
